yarvi_trace_buf: RTL and testbench

//  Parametrised retirement trace capture for the yarvi core. Takes the same per-retire

---
 rtl/yarvi_trace_buf_if.sv | 33 +++
 rtl/yarvi_trace_buf.sv | 175 +++++++++++++++++
 tb/tb_yarvi_trace_buf.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yarvi_trace_buf_if.sv
// Retire record input and drain stream bundle for yarvi_trace_buf.
// The core/test side is master; the trace buffer is slave.
interface yarvi_trace_buf_if #(
    parameter int XLEN = 32
);
    logic            ret_valid;
    logic [1:0]      ret_prv;
    logic [XLEN-1:0] ret_pc;
    logic [31:0]     ret_insn;
    logic [4:0]      ret_rd;
    logic [XLEN-1:0] ret_val;

    logic            rd_valid;
    logic            rd_ready;
    logic [1:0]      rd_prv;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_insn;
    logic [4:0]      rd_rd;
    logic [XLEN-1:0] rd_val;
    logic            rd_last;

    modport master (
        output ret_valid, ret_prv, ret_pc, ret_insn, ret_rd, ret_val,
        output rd_ready,
        input  rd_valid, rd_prv, rd_pc, rd_insn, rd_rd, rd_val, rd_last
    );

    modport slave (
        input  ret_valid, ret_prv, ret_pc, ret_insn, ret_rd, ret_val,
        input  rd_ready,
        output rd_valid, rd_prv, rd_pc, rd_insn, rd_rd, rd_val, rd_last
    );
endinterface

// File: rtl/yarvi_trace_buf.sv
// Retirement trace ring for the yarvi core: capture until a PC trigger
// plus POST records, then drain the window oldest-first.
module yarvi_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int POST  = 16,
    parameter int CNTW  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [XLEN-1:0]   trig_pc,
    yarvi_trace_buf_if.slave  bus,
    output logic [1:0]        state,
    output logic [CNTW-1:0]   ret_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [AW-1:0] POST_L = AW'(POST);
    localparam logic [FW-1:0] FULL   = FW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DRAIN   = 2'd3
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   wp_q;
    logic [FW-1:0]   fill_q;
    logic [AW-1:0]   post_cnt_q;
    logic [CNTW-1:0] cnt_q;

    logic            rd_valid_q;
    logic            rd_last_q;
    logic [1:0]      rd_prv_q;
    logic [XLEN-1:0] rd_pc_q;
    logic [31:0]     rd_insn_q;
    logic [4:0]      rd_rd_q;
    logic [XLEN-1:0] rd_val_q;

    logic [1:0]      mem_prv  [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [31:0]     mem_insn [DEPTH];
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_val  [DEPTH];

    logic            capturing;
    logic            wr_en;
    logic            hit;
    logic [AW-1:0]   wp_d;
    logic [FW-1:0]   fill_d;
    logic [AW-1:0]   rp;
    logic            load;
    logic            done;
    logic [XLEN-1:0] wr_val;

    always_comb begin
        capturing = (state_q == S_CAPTURE) || (state_q == S_POST);
        wr_en     = capturing && bus.ret_valid && !arm;
        hit       = trig_en && bus.ret_valid && (bus.ret_pc == trig_pc);
        wp_d      = wp_q + AW'(1);
        fill_d    = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
        // fill counts down while draining, so wp - fill is always the oldest left
        rp        = wp_q - fill_q[AW-1:0];
        load      = (state_q == S_DRAIN) && (fill_q != '0) &&
                    (!rd_valid_q || bus.rd_ready);
        done      = (state_q == S_DRAIN) && rd_valid_q && bus.rd_ready &&
                    rd_last_q;
        wr_val    = (bus.ret_rd == 5'd0) ? '0 : bus.ret_val;
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_prv[wp_q]  <= bus.ret_prv;
            mem_pc[wp_q]   <= bus.ret_pc;
            mem_insn[wp_q] <= bus.ret_insn;
            mem_rd[wp_q]   <= bus.ret_rd;
            mem_val[wp_q]  <= wr_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            fill_q     <= '0;
            post_cnt_q <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_prv_q   <= '0;
            rd_pc_q    <= '0;
            rd_insn_q  <= '0;
            rd_rd_q    <= '0;
            rd_val_q   <= '0;
        end else begin
            if (bus.ret_valid) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_q    <= S_CAPTURE;
                        wp_q       <= '0;
                        fill_q     <= '0;
                        post_cnt_q <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (arm) begin
                        wp_q       <= '0;
                        fill_q     <= '0;
                        post_cnt_q <= '0;
                    end else if (bus.ret_valid) begin
                        wp_q   <= wp_d;
                        fill_q <= fill_d;
                        if (hit) begin
                            if (POST == 0) begin
                                state_q <= S_DRAIN;
                            end else begin
                                state_q    <= S_POST;
                                post_cnt_q <= POST_L;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (arm) begin
                        state_q    <= S_CAPTURE;
                        wp_q       <= '0;
                        fill_q     <= '0;
                        post_cnt_q <= '0;
                    end else if (bus.ret_valid) begin
                        wp_q       <= wp_d;
                        fill_q     <= fill_d;
                        post_cnt_q <= post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (done) begin
                        state_q    <= S_IDLE;
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        fill_q     <= '0;
                    end else if (load) begin
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (fill_q == FW'(1));
                        rd_prv_q   <= mem_prv[rp];
                        rd_pc_q    <= mem_pc[rp];
                        rd_insn_q  <= mem_insn[rp];
                        rd_rd_q    <= mem_rd[rp];
                        rd_val_q   <= mem_val[rp];
                        fill_q     <= fill_q - FW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_prv   = rd_prv_q;
    assign bus.rd_pc    = rd_pc_q;
    assign bus.rd_insn  = rd_insn_q;
    assign bus.rd_rd    = rd_rd_q;
    assign bus.rd_val   = rd_val_q;
    assign state        = state_q;
    assign ret_count    = cnt_q;
endmodule

// File: tb/tb_yarvi_trace_buf.sv
// Bench for yarvi_trace_buf: two configurations share one stimulus path,
// checked against a queue-based window model.
module tb_yarvi_trace_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        ret_valid = 1'b0;
    logic [1:0]  ret_prv = '0;
    logic [31:0] ret_pc = '0;
    logic [31:0] ret_insn = '0;
    logic [4:0]  ret_rd = '0;
    logic [31:0] ret_val = '0;
    logic        rd_ready = 1'b0;
    int          dsel = 0;

    yarvi_trace_buf_if #(.XLEN(32)) ifa ();
    yarvi_trace_buf_if #(.XLEN(32)) ifb ();

    assign ifa.ret_valid = ret_valid && (dsel == 0);
    assign ifb.ret_valid = ret_valid && (dsel == 1);
    assign ifa.rd_ready  = rd_ready && (dsel == 0);
    assign ifb.rd_ready  = rd_ready && (dsel == 1);
    assign ifa.ret_prv   = ret_prv;
    assign ifb.ret_prv   = ret_prv;
    assign ifa.ret_pc    = ret_pc;
    assign ifb.ret_pc    = ret_pc;
    assign ifa.ret_insn  = ret_insn;
    assign ifb.ret_insn  = ret_insn;
    assign ifa.ret_rd    = ret_rd;
    assign ifb.ret_rd    = ret_rd;
    assign ifa.ret_val   = ret_val;
    assign ifb.ret_val   = ret_val;

    logic       arm_a, arm_b;
    logic [1:0] st_a, st_b;
    logic [31:0] cnt_a;
    logic [4:0]  cnt_b;
    assign arm_a = arm && (dsel == 0);
    assign arm_b = arm && (dsel == 1);

    yarvi_trace_buf #(.XLEN(32), .DEPTH(64), .POST(4), .CNTW(32)) dut_a (
        .clock(clk), .reset(reset), .arm(arm_a), .trig_en(trig_en),
        .trig_pc(trig_pc), .bus(ifa), .state(st_a), .ret_count(cnt_a)
    );

    yarvi_trace_buf #(.XLEN(32), .DEPTH(8), .POST(2), .CNTW(5)) dut_b (
        .clock(clk), .reset(reset), .arm(arm_b), .trig_en(trig_en),
        .trig_pc(trig_pc), .bus(ifb), .state(st_b), .ret_count(cnt_b)
    );

    logic        o_valid, o_last;
    logic [1:0]  o_prv, o_state;
    logic [31:0] o_pc, o_insn, o_val, o_cnt;
    logic [4:0]  o_rd;
    assign o_valid = (dsel == 0) ? ifa.rd_valid : ifb.rd_valid;
    assign o_last  = (dsel == 0) ? ifa.rd_last  : ifb.rd_last;
    assign o_prv   = (dsel == 0) ? ifa.rd_prv   : ifb.rd_prv;
    assign o_pc    = (dsel == 0) ? ifa.rd_pc    : ifb.rd_pc;
    assign o_insn  = (dsel == 0) ? ifa.rd_insn  : ifb.rd_insn;
    assign o_rd    = (dsel == 0) ? ifa.rd_rd    : ifb.rd_rd;
    assign o_val   = (dsel == 0) ? ifa.rd_val   : ifb.rd_val;
    assign o_state = (dsel == 0) ? st_a : st_b;
    assign o_cnt   = (dsel == 0) ? cnt_a : {27'd0, cnt_b};

    typedef struct packed {
        logic [1:0]  prv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] val;
    } rec_t;

    // Model: records written since the last arm, trimmed to the ring depth
    rec_t   win[$];
    int     mst[2];
    int     pcnt[2];
    longint rcnt[2];
    int     depth_m[2] = '{64, 8};
    int     post_m[2]  = '{4, 2};
    int     cntw_m[2]  = '{32, 5};
    int     ncmp = 0;
    int     nbad = 0;

    task automatic step();
        int d;
        longint mask;
        rec_t r;
        @(posedge clk);
        d = dsel;
        mask = (longint'(1) << cntw_m[d]) - 1;
        if (reset) begin
            mst = '{0, 0};
            pcnt = '{0, 0};
            rcnt = '{0, 0};
            win.delete();
        end else begin
            if (ret_valid) rcnt[d] = (rcnt[d] + 1) & mask;
            if (arm && mst[d] != 3) begin
                win.delete();
                mst[d] = 1;
                pcnt[d] = 0;
            end else if (ret_valid && (mst[d] == 1 || mst[d] == 2)) begin
                r = {ret_prv, ret_pc, ret_insn, ret_rd,
                     (ret_rd == 5'd0) ? 32'd0 : ret_val};
                win.push_back(r);
                if (win.size() > depth_m[d]) void'(win.pop_front());
                if (mst[d] == 1) begin
                    if (trig_en && ret_pc == trig_pc) begin
                        if (post_m[d] == 0) mst[d] = 3;
                        else begin
                            mst[d] = 2;
                            pcnt[d] = post_m[d];
                        end
                    end
                end else begin
                    pcnt[d]--;
                    if (pcnt[d] == 0) mst[d] = 3;
                end
            end
        end
        #1;
    endtask

    task automatic ret1(input bit v, input logic [31:0] pc, input bit a,
                        input logic [4:0] rd, input logic [31:0] val);
        ret_valid = v;
        arm = a;
        ret_prv = 2'($urandom);
        ret_pc = pc;
        ret_insn = $urandom;
        ret_rd = rd;
        ret_val = val;
        step();
        ret_valid = 1'b0;
        arm = 1'b0;
        ncmp++;
        if (o_state !== 2'(mst[dsel])) begin
            $display("FAIL state: got %0d want %0d", o_state, mst[dsel]);
            nbad++;
        end
    endtask

    task automatic drain_check(input int mode, input string nm);
        rec_t exp[$];
        rec_t cur, prevf;
        int n, got, cyc;
        bit pv, pr;
        exp = win;
        n = exp.size();
        got = 0;
        cyc = 0;
        pv = 0;
        pr = 0;
        prevf = '0;
        ncmp++;
        if (o_valid !== 1'b0) begin
            $display("FAIL %s entry_valid: got %b want 0", nm, o_valid);
            nbad++;
        end
        while (got < n && cyc < 4 * n + 20) begin
            cur = {o_prv, o_pc, o_insn, o_rd, o_val};
            if (cyc == 1) begin
                ncmp++;
                if (o_valid !== 1'b1) begin
                    $display("FAIL %s latency: got %b want 1", nm, o_valid);
                    nbad++;
                end
            end
            if (pv && !pr) begin
                ncmp++;
                if (o_valid !== 1'b1 || cur !== prevf) begin
                    $display("FAIL %s stall: got %b/%h want 1/%h",
                             nm, o_valid, cur, prevf);
                    nbad++;
                end
            end
            if (pv && pr) begin
                ncmp++;
                if (o_valid !== 1'b1) begin
                    $display("FAIL %s bubble: got %b want 1", nm, o_valid);
                    nbad++;
                end
            end
            rd_ready = (mode == 0) ? 1'b1 :
                       (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            ret_valid = 1'($urandom);
            arm = (mode == 2) && ($urandom_range(0, 3) == 0);
            ret_pc = trig_pc;
            ret_rd = 5'($urandom);
            ret_val = $urandom;
            if (o_valid && rd_ready) begin
                ncmp++;
                if (cur !== exp[got]) begin
                    $display("FAIL %s record%0d: got %h want %h",
                             nm, got, cur, exp[got]);
                    nbad++;
                end
                ncmp++;
                if (o_last !== (got == n - 1)) begin
                    $display("FAIL %s last%0d: got %b want %b",
                             nm, got, o_last, (got == n - 1));
                    nbad++;
                end
                got++;
            end
            pv = o_valid;
            pr = rd_ready;
            prevf = cur;
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        ret_valid = 1'b0;
        arm = 1'b0;
        ncmp++;
        if (got != n) begin
            $display("FAIL %s count: got %0d want %0d", nm, got, n);
            nbad++;
        end
        ncmp++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_state !== 2'd0) begin
            $display("FAIL %s end: got v%b l%b s%0d want v0 l0 s0",
                     nm, o_valid, o_last, o_state);
            nbad++;
        end
        mst[dsel] = 0;
        win.delete();
        ncmp++;
        if (o_cnt !== 32'(rcnt[dsel])) begin
            $display("FAIL %s ret_count: got %0d want %0d",
                     nm, o_cnt, rcnt[dsel]);
            nbad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            #1;
            ncmp++;
            if (o_state !== 2'd0 || o_valid !== 1'b0 || o_last !== 1'b0) begin
                $display("FAIL reset_ctl%0d: got s%0d v%b l%b want 0",
                         d, o_state, o_valid, o_last);
                nbad++;
            end
            ncmp++;
            if ({o_prv, o_pc, o_insn, o_rd, o_val} !== 103'd0) begin
                $display("FAIL reset_rd%0d: got %h want 0",
                         d, {o_prv, o_pc, o_insn, o_rd, o_val});
                nbad++;
            end
            ncmp++;
            if (o_cnt !== 32'd0) begin
                $display("FAIL reset_cnt%0d: got %0d want 0", d, o_cnt);
                nbad++;
            end
        end
        dsel = 0;
    endtask

    task automatic test_basic(input int mode, input string nm);
        dsel = 0;
        ret1(0, 0, 1, 0, 0);
        trig_en = 1'b1;
        trig_pc = 32'h108;
        for (int i = 0; i < 10 && mst[0] != 3; i++)
            ret1(1, 32'h100 + 4 * i, 0, 5'($urandom), $urandom);
        drain_check(mode, nm);
    endtask

    task automatic test_wrap();
        dsel = 1;
        ret1(0, 0, 1, 0, 0);
        trig_en = 1'b1;
        trig_pc = 32'h1000 + 4 * 17;
        for (int i = 0; i < 20 && mst[1] != 3; i++)
            ret1(1, 32'h1000 + 4 * i, 0, 5'($urandom), $urandom);
        drain_check(0, "wrap");
    endtask

    task automatic test_rearm();
        dsel = 0;
        ret1(0, 0, 1, 0, 0);
        trig_en = 1'b1;
        trig_pc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) ret1(0, 32'h200, 0, 1, 1);
            ret1(1, 32'h300 + 4 * i, 0, 5'($urandom), $urandom);
        end
        ret1(1, 32'h200, 1, 5'($urandom), $urandom);
        trig_en = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) ret1(0, 32'h200, 0, 1, 1);
            ret1(1, (i % 3 == 0) ? 32'h200 : 32'h400 + 4 * i, 0,
                 5'($urandom), $urandom);
        end
        trig_en = 1'b1;
        ret1(1, 32'h200, 0, 5'($urandom), $urandom);
        for (int i = 0; i < 4; i++)
            ret1(1, 32'h500 + 4 * i, 0, 5'($urandom), $urandom);
        drain_check(2, "rearm");
    endtask

    task automatic test_reset_mid();
        int hs, cyc;
        dsel = 0;
        ret1(0, 0, 1, 0, 0);
        trig_en = 1'b1;
        trig_pc = 32'h108;
        for (int i = 0; i < 10 && mst[0] != 3; i++)
            ret1(1, 32'h100 + 4 * i, 0, 5'($urandom), $urandom);
        rd_ready = 1'b1;
        hs = 0;
        cyc = 0;
        while (hs < 2 && cyc < 20) begin
            if (o_valid) hs++;
            step();
            cyc++;
        end
        ncmp++;
        if (o_valid !== 1'b1) begin
            $display("FAIL rstmid_pre: got %b want 1 (hs %0d)", o_valid, hs);
            nbad++;
        end
        ret_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ret_valid = 1'b0;
        rd_ready = 1'b0;
        ncmp++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_state !== 2'd0) begin
            $display("FAIL rstmid: got v%b l%b s%0d want v0 l0 s0",
                     o_valid, o_last, o_state);
            nbad++;
        end
        ncmp++;
        if (o_cnt !== 32'd0) begin
            $display("FAIL rstmid_cnt: got %0d want 0", o_cnt);
            nbad++;
        end
    endtask

    task automatic test_rd0_wrap();
        dsel = 1;
        ret1(0, 0, 1, 0, 0);
        trig_en = 1'b1;
        trig_pc = 32'h80;
        ret1(1, 32'h80, 0, 5'd0, 32'hDEADBEEF);
        ret1(1, 32'h84, 0, 5'd3, 32'h12345678);
        ret1(1, 32'h88, 0, 5'd0, 32'hCAFEF00D);
        drain_check(0, "rd0");
        for (int i = 0; i < 40 && rcnt[1] != 31; i++)
            ret1(1, 32'h90, 0, 1, 1);
        ncmp++;
        if (o_cnt !== 32'(rcnt[1]) || o_cnt !== 32'd31) begin
            $display("FAIL cnt_max: got %0d want %0d", o_cnt, rcnt[1]);
            nbad++;
        end
        ret1(1, 32'h90, 0, 1, 1);
        ncmp++;
        if (o_cnt !== 32'(rcnt[1])) begin
            $display("FAIL cnt_wrap: got %0d want %0d", o_cnt, rcnt[1]);
            nbad++;
        end
    endtask

    task automatic test_random();
        dsel = 1;
        for (int r = 0; r < 6; r++) begin
            ret1(0, 0, 1, 0, 0);
            trig_pc = 32'h40 + 4 * $urandom_range(0, 7);
            for (int c = 0; c < 400 && mst[1] != 3; c++) begin
                trig_en = ($urandom_range(0, 3) != 0);
                ret1($urandom_range(0, 3) != 0,
                     32'h40 + 4 * $urandom_range(0, 7),
                     $urandom_range(0, 15) == 0,
                     5'($urandom), $urandom);
            end
            ncmp++;
            if (mst[1] != 3) begin
                $display("FAIL rand_trigger%0d: got state %0d want 3",
                         r, o_state);
                nbad++;
            end else begin
                drain_check(2, "random");
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        mst = '{0, 0};
        pcnt = '{0, 0};
        rcnt = '{0, 0};
        test_reset();
        test_basic(0, "basic");
        test_wrap();
        test_basic(1, "stall");
        test_rearm();
        test_reset_mid();
        test_rd0_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
